register_bank_block: RTL and testbench

REGISTER_BANK_BLOCK -- requirements
Module: register_bank_block

---
 rtl/register_bank_block_pkg.sv | 14 +
 rtl/register_bank_block_regfile_32x16.sv | 54 +++++
 rtl/register_bank_block.sv | 89 ++++++++
 tb/tb_register_bank_block.sv | 133 +++++++++++++
 4 files changed

// File: rtl/register_bank_block_pkg.sv
// Shared widths and operand source-select encodings for the register bank block.
package register_bank_block_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        SEL_REG = 2'b00,
        SEL_EX  = 2'b01,
        SEL_DM  = 2'b10,
        SEL_WB  = 2'b11
    } sel_e;

endpackage

// File: rtl/register_bank_block_regfile_32x16.sv
// Register storage: two asynchronous read ports, one unconditional synchronous write port.
// Register 0 is hard-wired to zero; reads return pre-edge contents (no bypass).
module regfile_32x16
    import register_bank_block_pkg::*;
#(
    parameter int DATA_W = register_bank_block_pkg::DATA_W,
    parameter int ADDR_W = register_bank_block_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];

    // Storage update: clear everything on reset, otherwise write every edge except to register 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_addr != {ADDR_W{1'b0}}) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Read port A: register 0 forced to zero regardless of storage contents
    always_comb begin
        rd_data_a = {DATA_W{1'b0}};
        if (rd_addr_a == {ADDR_W{1'b0}}) begin
            rd_data_a = {DATA_W{1'b0}};
        end else begin
            rd_data_a = regs_r[rd_addr_a];
        end
    end

    // Read port B: register 0 forced to zero regardless of storage contents
    always_comb begin
        rd_data_b = {DATA_W{1'b0}};
        if (rd_addr_b == {ADDR_W{1'b0}}) begin
            rd_data_b = {DATA_W{1'b0}};
        end else begin
            rd_data_b = regs_r[rd_addr_b];
        end
    end

endmodule

// File: rtl/register_bank_block.sv
// Operand fetch stage: register file plus forwarding/immediate muxes feeding registered A and B.
module register_bank_block
    import register_bank_block_pkg::*;
#(
    parameter int DATA_W = register_bank_block_pkg::DATA_W,
    parameter int ADDR_W = register_bank_block_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic [DATA_W-1:0] ans_wb,
    input  logic [DATA_W-1:0] imm,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RW_dm,
    input  logic [1:0]        mux_sel_A,
    input  logic [1:0]        mux_sel_B,
    input  logic              imm_sel,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B
);

    logic [DATA_W-1:0] reg_a_s;
    logic [DATA_W-1:0] reg_b_s;
    logic [DATA_W-1:0] fwd_a_s;
    logic [DATA_W-1:0] fwd_b_s;
    logic [DATA_W-1:0] oper_b_s;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;

    regfile_32x16 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (RA),
        .rd_addr_b (RB),
        .wr_addr   (RW_dm),
        .wr_data   (ans_dm),
        .rd_data_a (reg_a_s),
        .rd_data_b (reg_b_s)
    );

    // Operand A source: register file or one of the forwarded pipeline results
    always_comb begin
        fwd_a_s = {DATA_W{1'b0}};
        case (mux_sel_A)
            SEL_REG: fwd_a_s = reg_a_s;
            SEL_EX:  fwd_a_s = ans_ex;
            SEL_DM:  fwd_a_s = ans_dm;
            SEL_WB:  fwd_a_s = ans_wb;
            default: fwd_a_s = {DATA_W{1'b0}};
        endcase
    end

    // Operand B source: same forwarding choice, then the immediate overrides it
    always_comb begin
        fwd_b_s = {DATA_W{1'b0}};
        case (mux_sel_B)
            SEL_REG: fwd_b_s = reg_b_s;
            SEL_EX:  fwd_b_s = ans_ex;
            SEL_DM:  fwd_b_s = ans_dm;
            SEL_WB:  fwd_b_s = ans_wb;
            default: fwd_b_s = {DATA_W{1'b0}};
        endcase
        if (imm_sel) begin
            oper_b_s = imm;
        end else begin
            oper_b_s = fwd_b_s;
        end
    end

    // Output operand registers, one cycle behind the selects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= {DATA_W{1'b0}};
            b_r <= {DATA_W{1'b0}};
        end else begin
            a_r <= fwd_a_s;
            b_r <= oper_b_s;
        end
    end

    assign A = a_r;
    assign B = b_r;

endmodule

// File: tb/tb_register_bank_block.sv
// Directed, table-driven bench for register_bank_block with hand-computed expectations.
module tb_register_bank_block;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ans_ex = 16'h0000;
    logic [15:0] ans_dm = 16'h0000;
    logic [15:0] ans_wb = 16'h0000;
    logic [15:0] imm = 16'h0000;
    logic [4:0]  RA = 5'd0;
    logic [4:0]  RB = 5'd0;
    logic [4:0]  RW_dm = 5'd0;
    logic [1:0]  mux_sel_A = 2'b00;
    logic [1:0]  mux_sel_B = 2'b00;
    logic        imm_sel = 1'b0;
    logic [15:0] A;
    logic [15:0] B;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] ex, dm, wb, im;
        logic [4:0]  ra, rb, rw;
        logic [1:0]  sa, sb;
        logic        isel;
        logic [15:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs [10];

    register_bank_block dut (
        .clk       (clk),
        .rst       (rst),
        .ans_ex    (ans_ex),
        .ans_dm    (ans_dm),
        .ans_wb    (ans_wb),
        .imm       (imm),
        .RA        (RA),
        .RB        (RB),
        .RW_dm     (RW_dm),
        .mux_sel_A (mux_sel_A),
        .mux_sel_B (mux_sel_B),
        .imm_sel   (imm_sel),
        .A         (A),
        .B         (B)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ans_ex = v.ex; ans_dm = v.dm; ans_wb = v.wb; imm = v.im;
        RA = v.ra; RB = v.rb; RW_dm = v.rw;
        mux_sel_A = v.sa; mux_sel_B = v.sb; imm_sel = v.isel;
    endtask

    initial begin
        //            ex        dm        wb        imm       ra    rb    rw    sa     sb     isel  expA      expB
        vecs[0] = '{16'h0000, 16'hD000, 16'h0000, 16'h0000, 5'd0, 5'd7, 5'd7, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{16'h0000, 16'h1234, 16'h0000, 16'h0000, 5'd7, 5'd7, 5'd0, 2'b00, 2'b00, 1'b0, 16'hD000, 16'hD000};
        vecs[2] = '{16'hC000, 16'hD000, 16'hE000, 16'h0000, 5'd0, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0, 16'hC000, 16'h0000};
        vecs[3] = '{16'hC000, 16'hD000, 16'hE000, 16'h0000, 5'd0, 5'd0, 5'd0, 2'b10, 2'b11, 1'b0, 16'hD000, 16'hE000};
        vecs[4] = '{16'hC000, 16'hD000, 16'hE000, 16'hFFFF, 5'd0, 5'd0, 5'd0, 2'b11, 2'b01, 1'b1, 16'hE000, 16'hFFFF};
        vecs[5] = '{16'hC000, 16'hD000, 16'hE000, 16'hFFFF, 5'd0, 5'd0, 5'd0, 2'b00, 2'b10, 1'b1, 16'h0000, 16'hFFFF};
        vecs[6] = '{16'h0000, 16'hAAAA, 16'h0000, 16'h0000, 5'd6, 5'd7, 5'd6, 2'b00, 2'b00, 1'b0, 16'h0000, 16'hD000};
        vecs[7] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000, 5'd6, 5'd6, 5'd0, 2'b00, 2'b10, 1'b0, 16'hAAAA, 16'h0001};
        vecs[8] = '{16'h0000, 16'h5555, 16'h0000, 16'h8001, 5'd5, 5'd5, 5'd5, 2'b00, 2'b00, 1'b1, 16'h0000, 16'h8001};
        vecs[9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd5, 5'd6, 5'd0, 2'b00, 2'b00, 1'b0, 16'h5555, 16'hAAAA};

        // Power-on reset, asserted between clock edges
        #1 rst = 1'b1;
        #1;
        check("reset_A", A, 16'h0000);
        check("reset_B", B, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_A", i), A, vecs[i].exp_a);
            check($sformatf("vec%0d_B", i), B, vecs[i].exp_b);
        end

        // Mid-run reset with a write to R7 pending; outputs must clear before any edge
        @(negedge clk);
        RA = 5'd5; RB = 5'd6; RW_dm = 5'd7; ans_dm = 16'h7777;
        mux_sel_A = 2'b00; mux_sel_B = 2'b00; imm_sel = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_A_async", A, 16'h0000);
        check("midrst_B_async", B, 16'h0000);
        @(posedge clk);
        #1;
        check("midrst_A_held", A, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        RA = 5'd5; RB = 5'd7; RW_dm = 5'd0; ans_dm = 16'h0000;
        @(posedge clk);
        #1;
        check("post_rst_R5", A, 16'h0000);
        check("post_rst_R7", B, 16'h0000);

        // Normal writes resume after reset release
        @(negedge clk);
        RW_dm = 5'd3; ans_dm = 16'h3333; RA = 5'd6; RB = 5'd3;
        @(posedge clk);
        #1;
        check("post_rst_R6", A, 16'h0000);
        check("post_rst_collide_R3", B, 16'h0000);
        @(negedge clk);
        RW_dm = 5'd0; ans_dm = 16'h0000; RA = 5'd3; RB = 5'd31;
        @(posedge clk);
        #1;
        check("post_rst_write_R3", A, 16'h3333);
        check("post_rst_R31", B, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
